// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU pipeline control blocks: forwarding source
// encodings, the mult/div sequencing states and the register address width.
package ppu_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding source for one ID-stage source register.
// The youngest producer wins (EX > MEM > WB); r0 is never forwarded.
module fwd_select
   import ppu_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_rf_enable,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_rf_enable,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_rf_enable,
   output logic [1:0]        fwd
);

   // Priority match against the in-flight destinations
   always_comb begin
      fwd = FWD_RF;
      if (src != '0) begin
         if (ex_rf_enable && ex_rd == src)        fwd = FWD_EX;
         else if (mem_rf_enable && mem_rd == src) fwd = FWD_MEM;
         else if (wb_rf_enable && wb_rd == src)   fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage PPU pipeline: stage load
// enables, ID/EX bubbles, forwarding selects, branch PC steering, the
// multi-cycle mult/div (HI/LO) busy FSM and a saturating stall counter.
module pipeline_hazard_ctrl
   import ppu_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int REG_AW     = REG_AW_DEF,
   parameter int PERF_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_md_op,
   input  logic              id_hilo_read,
   input  logic              id_branch_taken,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_rf_enable,
   input  logic              ex_load_instr,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_rf_enable,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_rf_enable,
   output logic              le_pc,
   output logic              le_npc,
   output logic              le_if_id,
   output logic              id_ex_bubble,
   output logic              pc_sel,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              md_start,
   output logic              md_busy,
   output logic              hilo_we,
   output logic [PERF_W-1:0] stall_count
);

   localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

   md_state_e              state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   load_use, md_hazard, stall;
   logic [1:0][REG_AW-1:0] src;
   logic [1:0][1:0]        fwd_raw;

   // While reset is held every hazard is masked so the outputs sit at their
   // RUN/no-hazard values regardless of what the stages present.
   assign load_use  = ex_load_instr && ex_rf_enable && (ex_rd != '0) &&
                      ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
   assign md_hazard = (state == MD_WAIT) && (id_md_op || id_hilo_read);
   assign stall     = reset && (load_use || md_hazard);

   assign le_pc        = !stall;
   assign le_npc       = !stall;
   assign le_if_id     = !stall;
   assign id_ex_bubble = stall;
   // Delay-slot pipeline: a taken branch only redirects the PC, nothing is
   // flushed. A stalled branch is re-evaluated once the stall clears.
   assign pc_sel       = reset && !stall && id_branch_taken;

   // One forwarding selector per source operand (0 = rs, 1 = rt)
   assign src = {id_rt, id_rs};
   for (genvar i = 0; i < 2; i++) begin : g_fwd
      fwd_select #(.REG_AW(REG_AW)) u_fwd (
         .src          (src[i]),
         .ex_rd        (ex_rd),
         .ex_rf_enable (ex_rf_enable),
         .mem_rd       (mem_rd),
         .mem_rf_enable(mem_rf_enable),
         .wb_rd        (wb_rd),
         .wb_rf_enable (wb_rf_enable),
         .fwd          (fwd_raw[i])
      );
   end
   assign fwd_a = reset ? fwd_raw[0] : FWD_RF;
   assign fwd_b = reset ? fwd_raw[1] : FWD_RF;

   // Mult/div state and remaining-cycle counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Issue from RUN when not stalled; count down in MD_WAIT and retire at zero
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      md_start  = 1'b0;
      case (state)
         RUN: begin
            if (reset && id_md_op && !stall) begin
               md_start  = 1'b1;
               state_nxt = MD_WAIT;
               cnt_nxt   = CNT_W'(MD_LATENCY - 1);
            end
         end
         MD_WAIT: begin
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = RUN;
      endcase
   end

   // Decoded purely from registered state, so reset clears both at once
   assign md_busy = (state == MD_WAIT);
   assign hilo_we = (state == MD_WAIT) && (cnt == '0);

   // Stall cycle counter, saturating at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            stall_count <= '0;
      else if (stall && stall_count != '1)   stall_count <= stall_count + PERF_W'(1);
   end

endmodule
